// File: rtl/violet_pkg.sv
// violet_pkg: shared constants and state encodings for the UART command receiver
// Optional macro CMD_FRAME_CHECKSUM_EN selects 4-byte frames with a trailing XOR checksum.
package violet_pkg;
  localparam logic [7:0] CMD_LEDS    = 8'd1;
  localparam logic [7:0] CMD_BTN     = 8'd2;
  localparam logic [7:0] CMD_DISPLAY = 8'd3;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef CMD_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {A_ADDR, A_DLO, A_DHI, A_CSUM} asm_state_t;
  localparam int FRAME_LEN = 4;
`else
  typedef enum logic [1:0] {A_ADDR, A_DLO, A_DHI} asm_state_t;
  localparam int FRAME_LEN = 3;
`endif
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser plus 8N1 byte receiver
// Ports: i_clk clock, rst async active-low reset, uart_rx serial line (idle high),
//        byte_valid/byte_data pulse with a good byte, byte_ferr pulse on a low stop bit.
module uart_rx_byte
  import violet_pkg::*;
#(
  parameter int BAUD_DIV = 128
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ferr
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  logic [1:0] sync_q;
  logic rx_s;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  assign rx_s = sync_q[1];
  assign byte_data = shift_q;
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end
  // Stop-bit handling returns to idle in the sampling cycle so a back-to-back start edge is not missed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
    case (state_q)
      RX_IDLE: if (!rx_s) begin
        cnt_d   = HALF;
        state_d = RX_START;
      end
      RX_START: if (cnt_q == '0) begin
        state_d = rx_s ? RX_IDLE : RX_DATA;
        cnt_d   = FULL;
        idx_d   = '0;
      end
      RX_DATA: if (cnt_q == '0) begin
        shift_d = {rx_s, shift_q[7:1]};
        cnt_d   = FULL;
        idx_d   = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt_q == '0) begin
        byte_valid = rx_s;
        byte_ferr  = !rx_s;
        state_d    = RX_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles UART bytes (addr, data_lo, data_hi) into single-cycle command pulses
// Ports: i_clk clock, rst async active-low reset, uart_rx serial line,
//        cmd_en/cmd_addr/cmd_data command output (held between frames), frame_err error pulse.
// Optional macro CMD_FRAME_CHECKSUM_EN adds a 4th byte that must equal addr ^ data_lo ^ data_hi.
module cmd_frame_rx
  import violet_pkg::*;
#(
  parameter int BAUD_DIV     = 128,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        cmd_en,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_err
);
  localparam int TMO = TIMEOUT_BITS * BAUD_DIV;
  localparam int GW = $clog2(TMO + 1);
  localparam asm_state_t LAST = asm_state_t'(2'(FRAME_LEN - 1));
  logic byte_valid, byte_ferr;
  logic [7:0] byte_data;
  asm_state_t state_q, state_d;
  logic [7:0] addr_q, addr_d, lo_q, lo_d, caddr_q, caddr_d;
  logic [15:0] cdata_q, cdata_d, frame_word;
  logic [GW-1:0] gap_q, gap_d;
  logic en_q, en_d, err_q, err_d;
  logic timeout, is_last, csum_ok;
  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .i_clk     (i_clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ferr (byte_ferr)
  );
`ifdef CMD_FRAME_CHECKSUM_EN
  logic [7:0] hi_q, hi_d;
  assign hi_d = (byte_valid && state_q == A_DHI) ? byte_data : hi_q;
  assign csum_ok = byte_data == (addr_q ^ lo_q ^ hi_q);
  assign frame_word = {hi_q, lo_q};
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) hi_q <= '0;
    else hi_q <= hi_d;
  end
`else
  assign csum_ok = 1'b1;
  assign frame_word = {byte_data, lo_q};
`endif
  assign timeout = state_q != A_ADDR && gap_q == GW'(TMO);
  assign is_last = state_q == LAST;
  // The gap counter restarts on each accepted byte and idles at zero while waiting for an address.
  assign gap_d = (byte_valid || timeout || state_q == A_ADDR) ? '0 : gap_q + 1'b1;
  assign cmd_en = en_q;
  assign frame_err = err_q;
  assign cmd_addr = caddr_q;
  assign cmd_data = cdata_q;
  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q <= A_ADDR;
      addr_q  <= '0;
      lo_q    <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
      err_q   <= err_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end
  // A byte arriving on the timeout cycle takes priority; a framing error and a timeout share one pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    if (byte_ferr) begin
      state_d = A_ADDR;
      err_d   = 1'b1;
    end else if (byte_valid) begin
      state_d = is_last ? A_ADDR : asm_state_t'(state_q + 2'd1);
      addr_d  = (state_q == A_ADDR) ? byte_data : addr_q;
      lo_d    = (state_q == A_DLO) ? byte_data : lo_q;
      en_d    = is_last && csum_ok;
      err_d   = is_last && !csum_ok;
      caddr_d = en_d ? addr_q : caddr_q;
      cdata_d = en_d ? frame_word : cdata_q;
    end else if (timeout) begin
      state_d = A_ADDR;
      err_d   = 1'b1;
    end
  end
endmodule

// File: tb/tb_cmd_frame_rx.sv
// tb_cmd_frame_rx: self-checking bench with a frame-level expected-event model
module tb_cmd_frame_rx;
  import violet_pkg::*;
  localparam int BD = 16;
  localparam int TB = 20;
  localparam int TMO = BD * TB;
`ifdef CMD_FRAME_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif
  typedef struct {
    bit          is_cmd;
    logic [7:0]  a;
    logic [15:0] d;
    int          lo;
    int          hi;
  } ev_t;
  logic i_clk = 0;
  logic rst = 0;
  logic uart_rx = 1;
  logic cmd_en, frame_err;
  logic [7:0] cmd_addr;
  logic [15:0] cmd_data;
  int total = 0, bad = 0, cyc = 0, n_cmd = 0, n_err = 0;
  int pos = 0, last_valid = 0;
  ev_t q[$];
  logic [7:0] fbuf [4];
  logic [7:0] hold_a = 0;
  logic [15:0] hold_d = 0;
  cmd_frame_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TB)) dut (
    .i_clk(i_clk), .rst(rst), .uart_rx(uart_rx),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .frame_err(frame_err)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  function automatic void push(bit c, logic [7:0] a, logic [15:0] d, int t);
    ev_t e;
    e.is_cmd = c; e.a = a; e.d = d; e.lo = t - 5; e.hi = t + 6;
    q.push_back(e);
  endfunction
  // A partial frame is dropped TMO clocks after its last accepted byte.
  function automatic void model_gap(int t);
    if (pos != 0 && t > last_valid + TMO) begin
      push(0, 0, 0, last_valid + TMO + 1);
      pos = 0;
    end
  endfunction
  // A byte whose start bit begins at cycle s is resolved about 2 + 9.5*BD clocks later.
  function automatic void model_byte(logic [7:0] b, bit ok, int s);
    model_gap(s + 152);
    if (!ok) begin
      push(0, 0, 0, s + 153);
      pos = 0;
    end else begin
      fbuf[pos] = b;
      pos++;
      last_valid = s + 153;
      if (pos == FLEN) begin
        pos = 0;
        if (FLEN == 4 && fbuf[3] != (fbuf[0] ^ fbuf[1] ^ fbuf[2])) push(0, 0, 0, s + 153);
        else push(1, fbuf[0], {fbuf[2], fbuf[1]}, s + 153);
      end
    end
  endfunction
  always @(negedge i_clk) begin
    ev_t e;
    if (!rst) begin
      chk("reset_outputs", {cmd_en, frame_err, cmd_addr, cmd_data}, 0);
      hold_a = 0;
      hold_d = 0;
    end else begin
      if (cmd_en) n_cmd++;
      if (frame_err) n_err++;
      if (cmd_en || frame_err) begin
        if (q.size() == 0) chk("unexpected_event", {cmd_en, frame_err}, 0);
        else begin
          e = q.pop_front();
          chk("event_kind", {cmd_en, frame_err}, e.is_cmd ? 2'b10 : 2'b01);
          chk("event_time", (cyc >= e.lo && cyc <= e.hi), 1);
          if (e.is_cmd) begin
            chk("cmd_addr", cmd_addr, e.a);
            chk("cmd_data", cmd_data, e.d);
            hold_a = e.a;
            hold_d = e.d;
          end
        end
      end
      if (!cmd_en) chk("held_outputs", {cmd_addr, cmd_data}, {hold_a, hold_d});
    end
  end
  task automatic tick(int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  task automatic idle(int n);
    model_gap(cyc + n);
    tick(n);
  endtask
  task automatic send_byte(logic [7:0] b, bit ok = 1);
    model_byte(b, ok, cyc);
    uart_rx = 0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BD);
    end
    uart_rx = ok;
    tick(BD * 3 / 4);
    uart_rx = 1;
    tick(BD / 4);
  endtask
  task automatic send_frame(logic [7:0] a, logic [7:0] lo, logic [7:0] hi, int gap = 0);
    send_byte(a); idle(gap);
    send_byte(lo); idle(gap);
    send_byte(hi);
`ifdef CMD_FRAME_CHECKSUM_EN
    idle(gap);
    send_byte(a ^ lo ^ hi);
`endif
  endtask
  task automatic settle();
    idle(400);
    chk("pending_events", q.size(), 0);
  endtask
  task automatic counts(string n, int c0, int e0, int dc, int de);
    chk({n, "_cmd_count"}, n_cmd - c0, dc);
    chk({n, "_err_count"}, n_err - e0, de);
  endtask
  initial begin
    int c0, e0, kind, at;
    logic [7:0] fb [4];
    tick(3);
    chk("rst_cmd_en", cmd_en, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_data", cmd_data, 0);
    rst = 1;
    tick(5);
    c0 = n_cmd; e0 = n_err;
    send_frame(CMD_BTN, 8'h34, 8'h12);
    settle();
    counts("basic", c0, e0, 1, 0);
    chk("basic_addr", cmd_addr, 8'h02);
    chk("basic_data", cmd_data, 16'h1234);
    c0 = n_cmd; e0 = n_err;
    send_byte(CMD_LEDS);
    send_byte(8'hAA);
    idle(400);
    counts("timeout", c0, e0, 0, 1);
    send_frame(CMD_DISPLAY, 8'h00, 8'h80);
    settle();
    chk("after_timeout_addr", cmd_addr, 8'h03);
    chk("after_timeout_data", cmd_data, 16'h8000);
    c0 = n_cmd; e0 = n_err;
    send_byte(CMD_LEDS);
    send_byte(8'h77, 0);
    settle();
    counts("stop_err", c0, e0, 0, 1);
    chk("stop_err_data_kept", cmd_data, 16'h8000);
    send_frame(CMD_LEDS, 8'hFF, 8'hFF);
    settle();
    chk("after_stop_err_data", cmd_data, 16'hFFFF);
    c0 = n_cmd; e0 = n_err;
    uart_rx = 0;
    tick(4);
    uart_rx = 1;
    idle(50);
    send_frame(CMD_BTN, 8'h01, 8'h00);
    settle();
    counts("glitch", c0, e0, 1, 0);
    chk("glitch_data", cmd_data, 16'h0001);
    send_byte(CMD_BTN);
    uart_rx = 0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0] ? 1'b0 : 1'b1;
      tick(BD);
    end
    rst = 0;
    q.delete();
    pos = 0;
    uart_rx = 1;
    tick(1);
    chk("midreset_addr", cmd_addr, 0);
    chk("midreset_data", cmd_data, 0);
    tick(2);
    rst = 1;
    idle(40);
    c0 = n_cmd; e0 = n_err;
    send_frame(CMD_BTN, 8'h55, 8'h66);
    settle();
    counts("after_reset", c0, e0, 1, 0);
    chk("after_reset_data", cmd_data, 16'h6655);
`ifdef CMD_FRAME_CHECKSUM_EN
    c0 = n_cmd; e0 = n_err;
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'h24);
    settle();
    counts("csum_good", c0, e0, 1, 0);
    chk("csum_good_data", cmd_data, 16'h1234);
    send_frame(CMD_LEDS, 8'h01, 8'h01);
    settle();
    c0 = n_cmd; e0 = n_err;
    send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'h25);
    settle();
    counts("csum_bad", c0, e0, 0, 1);
    chk("csum_bad_data_kept", cmd_data, 16'h0101);
`endif
    c0 = n_cmd; e0 = n_err;
    send_frame(CMD_LEDS, 8'h11, 8'h22);
    send_frame(CMD_DISPLAY, 8'h33, 8'h44);
    send_frame(8'hF0, 8'h55, 8'h66);
    settle();
    counts("back_to_back", c0, e0, 3, 0);
    chk("back_to_back_addr", cmd_addr, 8'hF0);
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 7);
      at = $urandom_range(0, FLEN - 1);
      fb[0] = 8'($urandom);
      fb[1] = 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = fb[0] ^ fb[1] ^ fb[2];
      if (kind == 2) fb[3] = fb[3] ^ 8'h01;
      for (int k = 0; k < FLEN; k++) begin
        send_byte(fb[k], !(kind == 0 && k == at));
        if (kind == 1 && k == at && k < FLEN - 1) idle(400 + $urandom_range(0, 50));
        else idle($urandom_range(0, 30));
      end
    end
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
